local_bias_ctrl: RTL and testbench
==================================

// Module: local_bias_ctrl
// PURPOSE
//  Digital power-up sequencer and analog-testbus controller for the local_bias analog macro.
//  Drives the macro's pdb and atb_ena inputs; consumes supply-good flags from the vddana_1p8 / vddana_0p8 / vssana monitors.
//  Enables the bias only after the supplies are debounced, flags bias_ready after a settle time, and switches the testbus break-before-make.
//  Drops bias on supply loss and records a sticky fault.
// PARAMETERS
//  SUP_DEBOUNCE  16   consecutive cycles all supplies must read good before pdb rises
//  BIAS_SETTLE   256  cycles from pdb rise to bias_ready
//  ATB_GAP       4    cycles atb_ena is held at 2'b00 between testbus selections
// PORTS
//  clk         in   1  block clock
//  rstb        in   1  reset, asynchronous assert, active-low
//  en          in   1  software enable for the local bias
//  vdd1p8_ok   in   1  vddana_1p8 in-range flag (async, from analog monitor)
//  vdd0p8_ok   in   1  vddana_0p8 in-range flag (async)
//  vss_ok      in   1  vssana in-range flag (async)
//  atb_sel     in   2  requested testbus selection (sync to clk)
//  fault_clr   in   1  single-cycle pulse; clears fault and leaves FAULT state
//  pdb         out  1  to local_bias.pdb; 1 = bias powered
//  atb_ena     out  2  to local_bias.atb_ena
//  bias_ready  out  1  bias currents settled
//  fault       out  1  sticky supply-loss flag
//  state       out  3  current FSM state, for status readback
// BEHAVIOUR
//  - Reset values: pdb=0, atb_ena=2'b00, bias_ready=0, fault=0, state=IDLE, all counters=0.
//  - Synchronisation: each *_ok passes through a 2-FF synchroniser. sup_ok = AND of the synchronised flags (2-cycle latency).
//  - All outputs are registered.
//  - FSM states: IDLE, DEBOUNCE, SETTLE, READY, FAULT.
//  - IDLE: pdb=0. If en && sup_ok -> DEBOUNCE, with cnt=0.
//  - DEBOUNCE: pdb=0; cnt++ while sup_ok.
//    - !sup_ok clears cnt to 0 and stays in DEBOUNCE.
//    - !en -> IDLE.
//    - cnt==SUP_DEBOUNCE-1 && sup_ok -> SETTLE, with cnt=0.
//  - SETTLE: pdb=1; cnt++.
//    - cnt==BIAS_SETTLE-1 -> READY.
//  - READY: pdb=1, bias_ready=1.
//  - Supply loss in SETTLE or READY: !sup_ok -> FAULT.
//    - FAULT: pdb=0, bias_ready=0 and atb_ena=00 on the cycle after entry; fault=1.
//  - Orderly shutdown: !en in SETTLE or READY -> IDLE with no fault.
//  - Priority: if !sup_ok and !en occur in the same cycle, FAULT wins.
//  - FAULT exit: stays until a fault_clr pulse -> IDLE, and fault clears on the same edge.
//    - fault_clr outside FAULT is ignored.
//  - Testbus: atb_ena is 2'b00 in every state except READY.
//    - On READY entry, and on any change of atb_sel while in READY: atb_ena=00 for ATB_GAP cycles, then atb_ena=atb_sel.
//    - An atb_sel change during the gap restarts the gap.
//    - 2'b11 is legal and drives both atb lines.
//  - Counters: width $clog2(max(SUP_DEBOUNCE,BIAS_SETTLE,ATB_GAP))+1, saturating, no wrap.
//  - Reset mid-operation: rstb low forces pdb=0 and atb_ena=00 asynchronously; all state is lost.
// STRUCTURE
//  - Package local_bias_pkg holds:
//    - typedef enum logic [2:0] lb_state_e {IDLE, DEBOUNCE, SETTLE, READY, FAULT};
//    - localparam ATB_OFF = 2'b00.
//  - Sub-module lb_sync2 is a 2-FF synchroniser; three instances, one per supply flag.
//  - Top level holds the FSM, the shared cnt, the atb gap counter and the output registers.
// TESTING
//  1. Nominal power-up: en=1, all ok=1 from t0.
//     -> pdb rises 2+16 cycles after sup_ok.
//     -> bias_ready rises 256 cycles later.
//     -> atb_ena stays 00 (atb_sel=00).
//  2. Debounce glitch: vdd0p8_ok low for 1 cycle at debounce count 10.
//     -> counter restarts; pdb rises 16 cycles after the glitch clears.
//  3. Testbus switch in READY: atb_sel 01 -> 10.
//     -> atb_ena: 01, then 00 for 4 cycles, then 10.
//     -> a 10 -> 11 change during the gap restarts the gap.
//  4. Supply loss in READY with atb_ena=11: vdd1p8_ok=0.
//     -> FAULT; pdb=0, atb_ena=00, bias_ready=0, fault=1.
//     -> supply recovery alone does not restart; fault_clr -> IDLE, then a full re-sequence.
//  5. Simultaneous en=0 and vss_ok=0 in SETTLE -> FAULT and fault=1 (not IDLE).
//  6. rstb low mid-SETTLE -> pdb=0 immediately; after release, state=IDLE and all outputs at reset values.

Source files
------------

// File: rtl/local_bias_pkg.sv
// Shared types and constants for the local_bias power-up sequencer.
package local_bias_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    SETTLE   = 3'd2,
    READY    = 3'd3,
    FAULT    = 3'd4
  } lb_state_e;

  // Testbus "both lines released" code.
  localparam logic [1:0] ATB_OFF = 2'b00;

  // Largest of three timing parameters; sizes the shared counters.
  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/local_bias_ctrl_if.sv
// Control/status bundle between the bias sequencer and its environment
// (software controls, supply monitors, analog macro pins, status readback).
interface local_bias_ctrl_if;
  import local_bias_pkg::*;

  logic       en;
  logic       vdd1p8_ok;
  logic       vdd0p8_ok;
  logic       vss_ok;
  logic [1:0] atb_sel;
  logic       fault_clr;
  logic       pdb;
  logic [1:0] atb_ena;
  logic       bias_ready;
  logic       fault;
  lb_state_e  state;

  // Environment side: drives controls and supply flags, observes macro pins.
  modport master (
    output en, vdd1p8_ok, vdd0p8_ok, vss_ok, atb_sel, fault_clr,
    input  pdb, atb_ena, bias_ready, fault, state
  );

  // Sequencer side.
  modport slave (
    input  en, vdd1p8_ok, vdd0p8_ok, vss_ok, atb_sel, fault_clr,
    output pdb, atb_ena, bias_ready, fault, state
  );

endinterface

// File: rtl/lb_sync2.sv
// Two-flop synchroniser for an asynchronous supply-monitor flag.
module lb_sync2 (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw flag through two flops; both clear so supplies read bad out of reset.
  // NOTE: these are plain flops, so they take the async reset; only RAM-style arrays should go without one.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/local_bias_ctrl.sv
// Power-up sequencer and break-before-make testbus controller for the
// local_bias analog macro. Debounces the supply-good flags, powers the bias,
// waits for it to settle, and drops everything with a sticky fault on supply loss.
module local_bias_ctrl
  import local_bias_pkg::*;
#(
  parameter int SUP_DEBOUNCE = 16,
  parameter int BIAS_SETTLE  = 256,
  parameter int ATB_GAP      = 4
) (
  input  logic               clk,
  input  logic               rstb,
  local_bias_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(max3(SUP_DEBOUNCE, BIAS_SETTLE, ATB_GAP)) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(SUP_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(BIAS_SETTLE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(ATB_GAP - 1);

  logic [2:0]       ok_sync;
  logic             sup_ok;
  lb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] gap_q;
  logic [1:0]       sel_q;
  logic [1:0]       atb_ena_q;
  logic             pdb_q;
  logic             bias_ready_q;
  logic             fault_q;

  lb_sync2 u_sync_1p8 (.clk(clk), .rstb(rstb), .d(bus.vdd1p8_ok), .q(ok_sync[0]));
  lb_sync2 u_sync_0p8 (.clk(clk), .rstb(rstb), .d(bus.vdd0p8_ok), .q(ok_sync[1]));
  lb_sync2 u_sync_vss (.clk(clk), .rstb(rstb), .d(bus.vss_ok),    .q(ok_sync[2]));

  assign sup_ok = &ok_sync;

  // Next-state and shared-counter logic; supply loss outranks a software disable.
  // NOTE: every target gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en && sup_ok) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!bus.en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!sup_ok) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (!sup_ok) begin
          state_d = FAULT;
          cnt_d   = '0;
        end else if (!bus.en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (!sup_ok)      state_d = FAULT;
        else if (!bus.en) state_d = IDLE;
      end
      FAULT: begin
        if (bus.fault_clr) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would create order-dependent races.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Macro control outputs, registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pdb_q        <= 1'b0;
      bias_ready_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pdb_q        <= (state_d == SETTLE) || (state_d == READY);
      bias_ready_q <= (state_d == READY);
      fault_q      <= (state_d == FAULT);
    end
  end

  // Testbus: hold both lines off for ATB_GAP cycles on READY entry or any
  // selection change (restarting on further changes), then drive the selection.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      atb_ena_q <= ATB_OFF;
      gap_q     <= '0;
      sel_q     <= ATB_OFF;
    end else if (state_d != READY) begin
      atb_ena_q <= ATB_OFF;
      gap_q     <= '0;
    end else if ((state_q != READY) || (bus.atb_sel != sel_q)) begin
      atb_ena_q <= ATB_OFF;
      gap_q     <= '0;
      sel_q     <= bus.atb_sel;
    end else if (gap_q == GAP_LAST) begin
      atb_ena_q <= sel_q;
    end else begin
      atb_ena_q <= ATB_OFF;
      gap_q     <= gap_q + 1'b1;
    end
  end

  assign bus.pdb        = pdb_q;
  assign bus.atb_ena    = atb_ena_q;
  assign bus.bias_ready = bias_ready_q;
  assign bus.fault      = fault_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_local_bias_ctrl.sv
// Directed bench for local_bias_ctrl: expectations are queued when stimulus
// is applied and compared against DUT outputs at the following falling edge.
module tb_local_bias_ctrl;
  import local_bias_pkg::*;

  logic clk = 1'b0;
  logic rstb;

  always #5 clk = ~clk;

  local_bias_ctrl_if bus ();

  local_bias_ctrl #(
    .SUP_DEBOUNCE(16),
    .BIAS_SETTLE (256),
    .ATB_GAP     (4)
  ) u_dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus)
  );

  typedef enum {SIG_PDB, SIG_ATB, SIG_BR, SIG_FAULT, SIG_STATE, SIG_LAT} sig_e;
  typedef struct {
    string tag;
    sig_e  sig;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat   = -1;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      SIG_PDB:   return 32'(bus.pdb);
      SIG_ATB:   return 32'(bus.atb_ena);
      SIG_BR:    return 32'(bus.bias_ready);
      SIG_FAULT: return 32'(bus.fault);
      SIG_STATE: return 32'(bus.state);
      default:   return 32'(lat);
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input int v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      n_cmp++;
      assert (obs === 32'(e.val)) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts falling edges until the signal reads 1; -1 if the budget runs out.
  task automatic measure_rise(input sig_e s, input int budget);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (observe(s) === 32'd1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_lat(input string tag, input sig_e s, input int exp_lat, input int budget);
    push(tag, SIG_LAT, exp_lat);
    measure_rise(s, budget);
    compare_all();
  endtask

  task automatic check_outs(input string tag, input int p, input int a, input int br,
                            input int f, input lb_state_e st);
    push({tag, ".pdb"},        SIG_PDB,   p);
    push({tag, ".atb_ena"},    SIG_ATB,   a);
    push({tag, ".bias_ready"}, SIG_BR,    br);
    push({tag, ".fault"},      SIG_FAULT, f);
    push({tag, ".state"},      SIG_STATE, int'(st));
    compare_all();
  endtask

  task automatic check_one(input string tag, input sig_e s, input int v);
    push(tag, s, v);
    compare_all();
  endtask

  initial begin
    rstb          = 1'b0;
    bus.en        = 1'b1;
    bus.vdd1p8_ok = 1'b1;
    bus.vdd0p8_ok = 1'b1;
    bus.vss_ok    = 1'b1;
    bus.atb_sel   = 2'b00;
    bus.fault_clr = 1'b0;
    step(3);
    check_outs("reset", 0, 0, 0, 0, IDLE);

    // 1. Nominal power-up. Raw flags good from release: 2 synchroniser edges,
    //    1 edge IDLE->DEBOUNCE, 16 debounce counts, so pdb follows edge 19.
    rstb = 1'b1;
    check_lat("t1.pdb_lat", SIG_PDB, 19, 60);
    check_lat("t1.ready_lat", SIG_BR, 256, 400);
    check_outs("t1.ready", 1, 0, 1, 0, READY);
    step(6);
    check_one("t1.atb_hold", SIG_ATB, 0);

    // Orderly shutdown from READY.
    bus.en = 1'b0;
    step(1);
    check_outs("shutdown", 0, 0, 0, 0, IDLE);

    // 2. Debounce glitch at count 10. Low raw pulse reaches the FSM two edges
    //    later and clears the count; 2 sync edges + 16 counts after recovery.
    bus.en = 1'b1;
    step(11);
    check_one("t2.debounce", SIG_STATE, int'(DEBOUNCE));
    bus.vdd0p8_ok = 1'b0;
    step(1);
    bus.vdd0p8_ok = 1'b1;
    check_lat("t2.pdb_lat", SIG_PDB, 18, 60);
    check_lat("t2.ready_lat", SIG_BR, 256, 400);

    // 3. Testbus break-before-make in READY.
    bus.atb_sel = 2'b01;
    step(4);
    check_one("t3.gap01", SIG_ATB, 0);
    step(1);
    check_one("t3.sel01", SIG_ATB, 1);
    bus.atb_sel = 2'b10;
    step(1);
    check_one("t3.break", SIG_ATB, 0);
    step(1);
    bus.atb_sel = 2'b11;
    step(3);
    check_one("t3.restart3", SIG_ATB, 0);
    step(1);
    check_one("t3.restart4", SIG_ATB, 0);
    step(1);
    check_one("t3.sel11", SIG_ATB, 3);
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    check_outs("t3.clr_ignored", 1, 3, 1, 0, READY);

    // 4. Supply loss in READY with both atb lines driven.
    bus.vdd1p8_ok = 1'b0;
    step(2);
    check_outs("t4.pre", 1, 3, 1, 0, READY);
    step(1);
    check_outs("t4.fault", 0, 0, 0, 1, FAULT);
    bus.vdd1p8_ok = 1'b1;
    step(8);
    check_outs("t4.hold", 0, 0, 0, 1, FAULT);
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    check_outs("t4.clear", 0, 0, 0, 0, IDLE);
    check_lat("t4.pdb_lat", SIG_PDB, 17, 60);
    check_lat("t4.ready_lat", SIG_BR, 256, 400);

    // 5. en drop and vss loss seen by the FSM on the same edge in SETTLE.
    bus.en = 1'b0;
    step(1);
    check_one("t5.idle", SIG_STATE, int'(IDLE));
    bus.en = 1'b1;
    check_lat("t5.pdb_lat", SIG_PDB, 17, 60);
    step(10);
    check_one("t5.settle", SIG_STATE, int'(SETTLE));
    bus.vss_ok = 1'b0;
    step(2);
    check_one("t5.pre", SIG_STATE, int'(SETTLE));
    bus.en = 1'b0;
    step(1);
    check_outs("t5.fault", 0, 0, 0, 1, FAULT);

    // Recover and re-sequence into SETTLE.
    bus.vss_ok = 1'b1;
    bus.en     = 1'b1;
    step(3);
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    check_outs("t6.clear", 0, 0, 0, 0, IDLE);
    check_lat("t6.pdb_lat", SIG_PDB, 17, 60);
    step(5);

    // 6. Asynchronous reset mid-SETTLE, between clock edges.
    #2;
    rstb = 1'b0;
    #1;
    check_outs("t6.async", 0, 0, 0, 0, IDLE);
    step(2);
    rstb = 1'b1;
    step(1);
    check_outs("t6.post", 0, 0, 0, 0, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
